// File: rtl/mac_pkg.sv
// mac_pkg - shared types and constants for the dadda_mac_8 block.
//
// Contents:
//   mac_state_t   : frame FSM states (IDLE, FILL, DRAIN, DONE)
//   PROD_W        : width of the 8x8 unsigned product
//   DEFAULT_ACC_W : default accumulator / result width
//   DEFAULT_LEN   : default number of products per frame
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  localparam int PROD_W        = 16;
  localparam int DEFAULT_ACC_W = 24;
  localparam int DEFAULT_LEN   = 4;

endpackage

// File: rtl/dadda_8.sv
// dadda_8 - combinational 8x8 unsigned multiplier built as a Dadda tree.
//
// Ports:
//   A [7:0]  : multiplicand
//   B [7:0]  : multiplier
//   y [15:0] : A * B
//
// The partial-product matrix is held column by column (bit weight = column
// index). Each stage reduces every column to the Dadda target height using
// half/full adders, with carries landing in the next column. The final two
// rows are summed with a plain carry-propagate adder.
module dadda_8
  import mac_pkg::*;
(
  input  logic [7:0]        A,
  input  logic [7:0]        B,
  output logic [PROD_W-1:0] y
);

  localparam int DEPTH  = 8;
  localparam int NCOL   = PROD_W + 1;
  localparam int STAGES = 4;

  logic [DEPTH-1:0]  col_bits [NCOL];
  int                col_h    [NCOL];
  logic [DEPTH-1:0]  nxt_bits [NCOL];
  int                nxt_h    [NCOL];
  logic [PROD_W-1:0] row_a;
  logic [PROD_W-1:0] row_b;
  int                eff;
  int                p;
  logic              x0, x1, x2, s, co;

  // Dadda height sequence for an 8-row matrix: 6, 4, 3, 2.
  function automatic int stage_target(input int st);
    case (st)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic bit_at(input logic [DEPTH-1:0] v, input int idx);
    logic [DEPTH-1:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic logic [DEPTH-1:0] put_bit(input logic [DEPTH-1:0] v,
                                               input int idx, input logic b);
    return v | (DEPTH'(b) << idx);
  endfunction

  // Column heights depend only on structure, so every loop below unrolls
  // to a fixed adder network.
  always_comb begin
    for (int c = 0; c < NCOL; c++) begin
      col_bits[c] = '0;
      col_h[c]    = 0;
      nxt_bits[c] = '0;
      nxt_h[c]    = 0;
    end
    eff = 0;
    p   = 0;
    x0  = 1'b0;
    x1  = 1'b0;
    x2  = 1'b0;
    s   = 1'b0;
    co  = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col_bits[i+j] = put_bit(col_bits[i+j], col_h[i+j], A[i] & B[j]);
        col_h[i+j]    = col_h[i+j] + 1;
      end
    end

    for (int st = 0; st < STAGES; st++) begin
      for (int c = 0; c < NCOL; c++) begin
        nxt_bits[c] = '0;
        nxt_h[c]    = 0;
      end
      for (int c = 0; c < NCOL - 1; c++) begin
        p   = 0;
        // Carries from column c-1 already sit in nxt_h[c].
        eff = col_h[c] + nxt_h[c];
        for (int k = 0; k < DEPTH / 2; k++) begin
          if (eff > stage_target(st)) begin
            x0 = bit_at(col_bits[c], p);
            x1 = bit_at(col_bits[c], p + 1);
            x2 = bit_at(col_bits[c], p + 2);
            if (eff == stage_target(st) + 1) begin
              s   = x0 ^ x1;
              co  = x0 & x1;
              p   = p + 2;
              eff = eff - 1;
            end else begin
              s   = x0 ^ x1 ^ x2;
              co  = (x0 & x1) | (x0 & x2) | (x1 & x2);
              p   = p + 3;
              eff = eff - 2;
            end
            nxt_bits[c]   = put_bit(nxt_bits[c], nxt_h[c], s);
            nxt_h[c]      = nxt_h[c] + 1;
            nxt_bits[c+1] = put_bit(nxt_bits[c+1], nxt_h[c+1], co);
            nxt_h[c+1]    = nxt_h[c+1] + 1;
          end
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (k >= p && k < col_h[c]) begin
            nxt_bits[c] = put_bit(nxt_bits[c], nxt_h[c], bit_at(col_bits[c], k));
            nxt_h[c]    = nxt_h[c] + 1;
          end
        end
      end
      for (int c = 0; c < NCOL; c++) begin
        col_bits[c] = nxt_bits[c];
        col_h[c]    = nxt_h[c];
      end
    end

    for (int c = 0; c < PROD_W; c++) begin
      row_a[c] = bit_at(col_bits[c], 0);
      row_b[c] = bit_at(col_bits[c], 1);
    end
  end

  assign y = row_a + row_b;

endmodule

// File: rtl/dadda_mac_8.sv
// dadda_mac_8 - pipelined 8x8 unsigned multiply-accumulate over fixed frames.
//
// Accepts LEN operand pairs per frame, multiplies each through a 3-stage
// pipeline (operand register, product register, accumulate) and presents the
// frame sum on y with a valid/ready handshake.
//
// Parameters:
//   LEN   : products per frame (1..256)
//   ACC_W : accumulator / result width (16..32)
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous frame abort (priority over everything else)
//   in_valid  : A/B pair valid          in_ready  : pair can be accepted
//   A, B      : unsigned 8-bit operands
//   out_valid : y holds a frame sum     out_ready : consumer takes y
//   y         : frame sum, straight from the accumulator register
//
// Build option:
//   DADDA_MAC_SAT_EN : when defined, the accumulator clamps at 2^ACC_W-1
//                      instead of wrapping.
module dadda_mac_8
  import mac_pkg::*;
#(
  parameter int LEN   = DEFAULT_LEN,
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] y
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  mac_state_t        state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic              s1_valid, s2_valid;
  logic [7:0]        s1_a, s1_b;
  logic [PROD_W-1:0] prod, s2_prod;
  logic [ACC_W-1:0]  acc, acc_sum;
  logic              accept, last_term, handshake, last_product;

  dadda_8 u_mult (
    .A (s1_a),
    .B (s1_b),
    .y (prod)
  );

  // in_ready is forced low during reset even though the state already reads IDLE.
  assign in_ready     = rst_n && ((state == IDLE) || (state == FILL)) && !clear;
  assign accept       = in_valid && in_ready;
  assign last_term    = accept && (count == CNT_W'(LEN - 1));
  assign handshake    = (state == DONE) && out_ready;
  // In DRAIN nothing new enters, so stage 2 valid with stage 1 empty is the last term.
  assign last_product = (state == DRAIN) && s2_valid && !s1_valid;
  assign out_valid    = (state == DONE);
  assign y            = acc;

`ifdef DADDA_MAC_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, acc} + (ACC_W + 1)'(s2_prod);
  assign acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign acc_sum  = acc + ACC_W'(s2_prod);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = last_term ? DRAIN : FILL;
        FILL:    if (last_term) state_nxt = DRAIN;
        DRAIN:   if (last_product) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pipeline, term counter and accumulator. Bubbles simply leave the stage
  // valids low, so they are never counted or added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      acc      <= '0;
      count    <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      acc      <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= A;
        s1_b <= B;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_prod <= prod;
      if (handshake)     acc <= '0;
      else if (s2_valid) acc <= acc_sum;
      if (handshake)      count <= '0;
      else if (last_term) count <= '0;
      else if (accept)    count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dadda_mac_8.sv
// tb_dadda_mac_8 - self-checking bench for dadda_mac_8.
// A 24-bit and a 16-bit instance share all inputs; the 16-bit one exposes
// overflow behaviour (wrap, or clamp when DADDA_MAC_SAT_EN is defined).
module tb_dadda_mac_8;

  localparam int LEN = 4;
`ifdef DADDA_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        in_ready, out_valid;
  logic [23:0] y24;
  logic        in_ready16, out_valid16;
  logic [15:0] y16;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [LEN-1:0][7:0] a;
    logic [LEN-1:0][7:0] b;
    int                  gap;
    longint              exp24;
    longint              exp16_wrap;
    longint              exp16_sat;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] cur_a [LEN];
  logic [7:0] cur_b [LEN];

  always #5 clk = ~clk;

  dadda_mac_8 #(.LEN(LEN), .ACC_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y24)
  );

  dadda_mac_8 #(.LEN(LEN), .ACC_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .A         (A),
    .B         (B),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .y         (y16)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Frame sum from the arithmetic definition: plain sum of products, then
  // wrapped to w bits or clamped at the w-bit maximum.
  function automatic longint modelY(input int w, input bit sat);
    longint total = 0;
    longint top   = (longint'(1) << w) - 1;
    for (int i = 0; i < LEN; i++) total += longint'(cur_a[i]) * longint'(cur_b[i]);
    if (sat) return (total > top) ? top : total;
    return total & top;
  endfunction

  // Offer one term; it must be taken on the next rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    #1;
    checkOutput("in_ready on offer", longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
    A        = 8'($urandom);
    B        = 8'($urandom);
  endtask

  task automatic loadRow(input int r);
    for (int i = 0; i < LEN; i++) begin
      cur_a[i] = vecs[r].a[i];
      cur_b[i] = vecs[r].b[i];
    end
  endtask

  task automatic releaseOut(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({name, " out_valid after take"}, longint'(out_valid), 0);
    checkOutput({name, " y after take"}, longint'(y24), 0);
  endtask

  task automatic runFrame(input string name, input int gap, input longint exp24,
                          input longint exp16, input bit do_release);
    int n;
    for (int i = 0; i < LEN; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          A        = 8'($urandom);
          B        = 8'($urandom);
          step();
        end
      end
      applyStimulus(cur_a[i], cur_b[i]);
    end
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    checkOutput({name, " edges to out_valid"}, longint'(n), 2);
    checkOutput({name, " y"}, longint'(y24), exp24);
    checkOutput({name, " y16"}, longint'(y16), exp16);
    checkOutput({name, " out_valid16"}, longint'(out_valid16), 1);
    if (do_release) begin
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        step();
        checkOutput({name, " y held"}, longint'(y24), exp24);
      end
      releaseOut(name);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{a: {8'd0, 8'd255, 8'd10, 8'd3}, b: {8'd77, 8'd255, 8'd10, 8'd5},
                gap: 0, exp24: 65140, exp16_wrap: 65140, exp16_sat: 65140};
    vecs[1] = '{a: {8'd0, 8'd255, 8'd10, 8'd3}, b: {8'd77, 8'd255, 8'd10, 8'd5},
                gap: 2, exp24: 65140, exp16_wrap: 65140, exp16_sat: 65140};
    vecs[2] = '{a: {4{8'd1}}, b: {4{8'd1}}, gap: 0, exp24: 4, exp16_wrap: 4, exp16_sat: 4};
    vecs[3] = '{a: {4{8'd2}}, b: {4{8'd3}}, gap: 1, exp24: 24, exp16_wrap: 24, exp16_sat: 24};
    vecs[4] = '{a: {4{8'd7}}, b: {4{8'd7}}, gap: 0, exp24: 196, exp16_wrap: 196, exp16_sat: 196};
    vecs[5] = '{a: {4{8'd255}}, b: {4{8'd255}}, gap: 0, exp24: 260100,
                exp16_wrap: 63492, exp16_sat: 65535};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;

    // Reset state
    #3;
    checkOutput("reset in_ready", longint'(in_ready), 0);
    checkOutput("reset in_ready16", longint'(in_ready16), 0);
    checkOutput("reset out_valid", longint'(out_valid), 0);
    checkOutput("reset y", longint'(y24), 0);
    checkOutput("reset y16", longint'(y16), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after release", longint'(in_ready), 1);

    // Table-driven frames
    for (int r = 0; r < 6; r++) begin
      loadRow(r);
      runFrame($sformatf("vec%0d", r), vecs[r].gap, vecs[r].exp24,
               SAT ? vecs[r].exp16_sat : vecs[r].exp16_wrap, 1'b1);
    end

    // Consumer stalls in DONE while terms are offered; nothing may be taken.
    loadRow(0);
    runFrame("stall", 0, 65140, 65140, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      A        = 8'($urandom_range(1, 255));
      B        = 8'($urandom_range(1, 255));
      #1;
      checkOutput("stall in_ready", longint'(in_ready), 0);
      step();
      checkOutput("stall y", longint'(y24), 65140);
      checkOutput("stall out_valid", longint'(out_valid), 1);
    end
    in_valid = 1'b0;
    releaseOut("stall");
    loadRow(2);
    runFrame("after stall", 0, 4, 4, 1'b1);

    // Clear after two accepted terms, with a term offered and out_ready high.
    applyStimulus(8'd9, 8'd9);
    applyStimulus(8'd9, 8'd9);
    in_valid  = 1'b1;
    A         = 8'd9;
    B         = 8'd9;
    clear     = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("clear in_ready", longint'(in_ready), 0);
    step();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("clear out_valid", longint'(out_valid), 0);
    checkOutput("clear y", longint'(y24), 0);
    checkOutput("clear in_ready after", longint'(in_ready), 1);
    repeat (3) step();
    checkOutput("clear in-flight discarded", longint'(y24), 0);
    loadRow(3);
    runFrame("after clear", 0, 24, 24, 1'b1);

    // Reset asserted mid-DRAIN
    loadRow(0);
    for (int i = 0; i < LEN; i++) applyStimulus(cur_a[i], cur_b[i]);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset in_ready", longint'(in_ready), 0);
    checkOutput("mid reset out_valid", longint'(out_valid), 0);
    checkOutput("mid reset y", longint'(y24), 0);
    checkOutput("mid reset y16", longint'(y16), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid reset in_ready after", longint'(in_ready), 1);
    repeat (3) step();
    checkOutput("mid reset no output", longint'(out_valid), 0);
    loadRow(4);
    runFrame("after reset", 0, 196, 196, 1'b1);

    // Randomized frames against the reference model
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < LEN; i++) begin
        if (f % 2 == 1) begin
          cur_a[i] = 8'($urandom_range(200, 255));
          cur_b[i] = 8'($urandom_range(200, 255));
        end else begin
          cur_a[i] = 8'($urandom);
          cur_b[i] = 8'($urandom);
        end
      end
      runFrame($sformatf("rand%0d", f), int'($urandom_range(0, 2)),
               modelY(24, SAT), modelY(16, SAT), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dadda_mac_8.md
DADDA_MAC_8 -- requirements
Module: dadda_mac_8

Interface
REQ-001 Parameter LEN, default 4, is the number of products accumulated per frame (legal range 1..256).
REQ-002 Parameter ACC_W, default 24, is the accumulator and result width (legal range 16..32).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 clear  input  1  synchronous frame abort.
REQ-006 in_valid  input  1  the A/B operand pair is valid.
REQ-007 in_ready  output  1  the block can accept an operand pair.
REQ-008 A  input  8  unsigned multiplicand.
REQ-009 B  input  8  unsigned multiplier.
REQ-010 out_valid  output  1  y holds a completed frame sum.
REQ-011 out_ready  input  1  the consumer takes y.
REQ-012 y  output  ACC_W  unsigned sum of LEN products A*B.

Function
REQ-013 A term SHALL be accepted on a rising edge where in_valid && in_ready && !clear.
REQ-014 An accepted term SHALL pass through a 3-stage pipeline:
- edge k: register A and B into stage 1.
- edge k+1: register the 16-bit product into stage 2.
- edge k+2: add the product to the accumulator, zero-extended to ACC_W.
REQ-015 The FSM SHALL have four states:
- IDLE: accumulator zero, no term accepted yet; in_ready=1.
- FILL: terms being accepted; in_ready=1.
- DRAIN: LEN terms accepted, pipeline emptying; in_ready=0.
- DONE: out_valid=1; in_ready=0.
REQ-016 The FSM SHALL leave IDLE for FILL on the first accepted term; with LEN=1 it SHALL go directly from IDLE to DRAIN.
REQ-017 The FSM SHALL move to DRAIN on the edge that accepts the LEN-th term.
REQ-018 The FSM SHALL move from DRAIN to DONE on the edge that accumulates the LEN-th product, so that out_valid is high after edge k+2 of the last term.
REQ-019 In DONE, y and out_valid SHALL hold stable until out_valid && out_ready.
REQ-020 On that handshake edge the block SHALL clear the accumulator and term counter and return to IDLE.
REQ-021 Gaps in in_valid SHALL insert pipeline bubbles; bubbles SHALL NOT be accumulated or counted.
REQ-022 The term counter SHALL count from 0 to LEN-1 and then reset to 0; the count SHALL never exceed LEN.
REQ-023 When clear=1, on that edge the block SHALL:
- invalidate both pipeline stages;
- zero the accumulator and the counter;
- force IDLE and drop out_valid.
REQ-024 clear SHALL take priority over a simultaneous in_valid or out_ready; the term is not accepted.
REQ-025 in_ready SHALL be combinational: in_ready = (state is IDLE or FILL) && !clear.
REQ-026 y SHALL be driven directly from the accumulator register, with no combinational path from A or B.
REQ-027 Without the saturation feature, accumulator overflow SHALL wrap modulo 2^ACC_W.

Reset
REQ-028 While rst_n=0 the block SHALL hold: state IDLE, accumulator 0, counter 0, stage valids 0, out_valid 0, y 0.
REQ-029 in_ready SHALL be 0 while rst_n=0, and 1 on the first cycle after release.
REQ-030 Asserting rst_n=0 mid-frame SHALL discard every in-flight term immediately, with no output produced.

Configuration
REQ-031 The macro DADDA_MAC_SAT_EN controls overflow handling.
REQ-032 With DADDA_MAC_SAT_EN defined, an accumulate that would exceed 2^ACC_W-1 SHALL clamp the accumulator to 2^ACC_W-1, and later adds in the same frame SHALL keep it there.
REQ-033 Without DADDA_MAC_SAT_EN, the block SHALL use wrap-around per REQ-027 and contain no clamp logic.

Structure
REQ-034 The package mac_pkg SHALL hold:
- the FSM state enum (IDLE, FILL, DRAIN, DONE);
- the product width constant (16);
- the default ACC_W and LEN constants.
REQ-035 The product SHALL come from one instance of the existing combinational multiplier dadda_8 (ports A, B, y), placed between stage 1 and stage 2.
REQ-036 The block SHALL contain no other sub-module.

Verification
REQ-037 LEN=4; terms (3,5), (10,10), (255,255), (0,77) back-to-back -> out_valid high 2 edges after the 4th acceptance, y=65140.
REQ-038 Same terms with 2-cycle in_valid gaps -> y=65140; bubbles not counted; out_valid exactly 2 edges after the last acceptance.
REQ-039 out_ready held low 5 cycles in DONE while in_valid=1 -> y is stable, in_ready=0, no term accepted; once out_ready=1, next frame (1,1)x4 -> y=4.
REQ-040 clear pulsed after 2 accepted terms (one of them in flight) -> IDLE, out_valid=0; next frame (2,3)x4 -> y=24.
REQ-041 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately; in_ready=1 after release; next frame (7,7)x4 -> y=196.
REQ-042 ACC_W=16, terms (255,255)x4 -> y=65535 with DADDA_MAC_SAT_EN, y=63492 without.
